ro_bank_ctrl: RTL and testbench

- Sequencing controller that sits directly upstream of a bank of NUM_RO ring-oscillator instances and drives their enable inputs.
- On a trigger pulse it ramps the number of enabled oscillators up one at a time, holds the target load for a programmed number of cycles, then ramps back down.
- The stepwise ramp bounds di/dt on the supply; sequencing is fully synchronous to the system clock.

---
 rtl/ro_bank_ctrl.sv | 159 +++++++++++++++
 tb/tb_ro_bank_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_bank_ctrl.sv
// Sequences thermometer-coded enables for a bank of ring oscillators: ramps up one
// oscillator per step, holds, then ramps down. All outputs are registered; no backpressure.
module ro_bank_ctrl #(
  parameter int NUM_RO = 16,
  localparam int LVL_W = $clog2(NUM_RO + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              abort,
  input  logic [LVL_W-1:0]  cfg_target,
  input  logic [15:0]       cfg_step_cycles,
  input  logic [31:0]       cfg_active_cycles,
  output logic [NUM_RO-1:0] ro_en,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_RO);

  logic [1:0]        r_state;
  logic [LVL_W-1:0]  r_level;
  logic [NUM_RO-1:0] r_ro_en;
  logic              r_done;
  logic [LVL_W-1:0]  r_tgt;
  logic [15:0]       r_step;
  logic [31:0]       r_act;
  logic [15:0]       r_step_cnt;
  logic [31:0]       r_hold_cnt;

  logic [1:0]        w_state_nxt;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [NUM_RO-1:0] w_ro_en_nxt;
  logic              w_done_nxt;
  logic [15:0]       w_step_cnt_nxt;
  logic [31:0]       w_hold_cnt_nxt;
  logic [LVL_W-1:0]  w_tgt_clamp;
  logic [15:0]       w_step_eff;
  logic [31:0]       w_act_eff;
  logic              w_start;
  logic              w_step_hit;
  logic              w_hold_hit;
  logic [LVL_W-1:0]  w_lvl_inc;
  logic [LVL_W-1:0]  w_lvl_dec;

  assign w_tgt_clamp = (cfg_target > MAX_LVL) ? MAX_LVL : cfg_target;
  assign w_step_eff  = (cfg_step_cycles == 16'd0) ? 16'd1 : cfg_step_cycles;
  assign w_act_eff   = (cfg_active_cycles == 32'd0) ? 32'd1 : cfg_active_cycles;
  assign w_start     = (r_state == IDLE) && trigger && !abort && (w_tgt_clamp != '0);
  assign w_step_hit  = (r_step_cnt == r_step - 16'd1);
  assign w_hold_hit  = (r_hold_cnt == r_act - 32'd1);
  assign w_lvl_inc   = r_level + LVL_W'(1);
  assign w_lvl_dec   = r_level - LVL_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_done_nxt     = 1'b0;
    w_step_cnt_nxt = r_step_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt    = RAMP_UP;
          w_level_nxt    = '0;
          w_step_cnt_nxt = '0;
        end else if (trigger && !abort) begin
          w_done_nxt = 1'b1;
        end
      end
      RAMP_UP: begin
        // abort keeps the current level; nothing is enabled yet if level is 0
        if (abort) begin
          w_step_cnt_nxt = '0;
          if (r_level == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RAMP_DOWN;
          end
        end else if (w_step_hit) begin
          w_level_nxt    = w_lvl_inc;
          w_step_cnt_nxt = '0;
          if (w_lvl_inc == r_tgt) begin
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = '0;
          end
        end else begin
          w_step_cnt_nxt = r_step_cnt + 16'd1;
        end
      end
      HOLD: begin
        if (abort || w_hold_hit) begin
          w_state_nxt    = RAMP_DOWN;
          w_step_cnt_nxt = '0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 32'd1;
        end
      end
      default: begin
        if (w_step_hit) begin
          w_level_nxt    = w_lvl_dec;
          w_step_cnt_nxt = '0;
          if (w_lvl_dec == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_step_cnt_nxt = r_step_cnt + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    w_ro_en_nxt = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      w_ro_en_nxt[i] = (i < int'(w_level_nxt));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_level    <= '0;
      r_ro_en    <= '0;
      r_done     <= 1'b0;
      r_tgt      <= '0;
      r_step     <= '0;
      r_act      <= '0;
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_ro_en    <= w_ro_en_nxt;
      r_done     <= w_done_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      if (w_start) begin
        r_tgt  <= w_tgt_clamp;
        r_step <= w_step_eff;
        r_act  <= w_act_eff;
      end
    end
  end

  assign ro_en = r_ro_en;
  assign level = r_level;
  assign busy  = (r_state != IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_ro_bank_ctrl.sv
// Scoreboarded bench for ro_bank_ctrl: expected per-edge outputs are derived from the
// closed-form sequence timeline and compared on the falling edge.
module tb_ro_bank_ctrl;

  localparam int NUM_RO = 8;
  localparam int LVL_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic              abort = 1'b0;
  logic [LVL_W-1:0]  cfg_target = '0;
  logic [15:0]       cfg_step_cycles = '0;
  logic [31:0]       cfg_active_cycles = '0;
  logic [NUM_RO-1:0] ro_en;
  logic [LVL_W-1:0]  level;
  logic              busy;
  logic              done;

  ro_bank_ctrl #(.NUM_RO(NUM_RO)) dut (
    .clk               (clk),
    .rst               (rst),
    .trigger           (trigger),
    .abort             (abort),
    .cfg_target        (cfg_target),
    .cfg_step_cycles   (cfg_step_cycles),
    .cfg_active_cycles (cfg_active_cycles),
    .ro_en             (ro_en),
    .level             (level),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int cyc;
    int en;
    int lvl;
    int bsy;
    int dn;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic push(input int cyc, input int lvl, input int bsy, input int dn);
    exp_t e;
    e.cyc = cyc;
    e.en  = (1 << lvl) - 1;
    e.lvl = lvl;
    e.bsy = bsy;
    e.dn  = dn;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int first, input int last);
    for (int c = first; c <= last; c++) push(c, 0, 0, 0);
  endtask

  function automatic int up_lvl(input int e, input int t0, input int tt, input int s);
    int d;
    d = (e - t0) / s;
    return (d > tt) ? tt : d;
  endfunction

  // t0: trigger edge, r: edge at which ramp-down (or abort) is taken, last: cut-off edge
  task automatic push_seq(input int t0, input int tt, input int s, input int r, input int last);
    int lr, end_e;
    lr    = up_lvl(r - 1, t0, tt, s);
    end_e = r + lr * s;
    for (int e = t0; e <= end_e && e <= last; e++) begin
      if (e < r) push(e, up_lvl(e, t0, tt, s), 1, 0);
      else push(e, lr - (e - r) / s, (e < end_e) ? 1 : 0, (e == end_e) ? 1 : 0);
    end
  endtask

  // returns just after edge e-1, so inputs set now are sampled at edge e
  task automatic at_edge(input int e);
    while (edge_n < e - 1) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input int t0, input int tgt, input int s, input int a);
    at_edge(t0);
    cfg_target        = LVL_W'(tgt);
    cfg_step_cycles   = 16'(s);
    cfg_active_cycles = 32'(a);
    trigger           = 1'b1;
    at_edge(t0 + 1);
    trigger           = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < edge_n) begin
      check_val("stale_entry", 32'(sb[0].cyc), 32'(edge_n));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      check_val("ro_en", 32'(ro_en), 32'(sb[0].en));
      check_val("level", 32'(level), 32'(sb[0].lvl));
      check_val("busy",  32'(busy),  32'(sb[0].bsy));
      check_val("done",  32'(done),  32'(sb[0].dn));
      void'(sb.pop_front());
    end
  end

  initial begin
    push_idle(1, 9);
    at_edge(4);
    rst = 1'b0;

    // nominal sequence; a trigger with new config mid-ramp must change nothing
    push_seq(10, 4, 2, 10 + 8 + 5, 1000);
    start(10, 4, 2, 5);
    at_edge(13);
    trigger         = 1'b1;
    cfg_target      = 4'd1;
    cfg_step_cycles = 16'd7;
    at_edge(14);
    trigger         = 1'b0;

    // trigger in the done cycle starts a new sequence
    push_seq(32, 2, 3, 32 + 6 + 1, 1000);
    push_idle(46, 49);
    start(32, 2, 3, 1);

    // zero step and active counts behave as 1
    push_seq(50, 2, 1, 53, 1000);
    push_idle(56, 59);
    start(50, 2, 0, 0);

    // target above NUM_RO clamps
    push_seq(60, 8, 1, 60 + 8 + 2, 1000);
    push_idle(79, 79);
    start(60, 15, 1, 2);

    // zero target: done pulse only
    push(80, 0, 0, 1);
    push_idle(81, 84);
    start(80, 0, 3, 3);

    // trigger together with abort in IDLE is ignored
    push_idle(85, 89);
    at_edge(85);
    trigger = 1'b1;
    abort   = 1'b1;
    at_edge(86);
    trigger = 1'b0;
    abort   = 1'b0;

    // abort during HOLD
    push_seq(90, 4, 2, 101, 1000);
    push_idle(110, 114);
    start(90, 4, 2, 20);
    at_edge(101);
    abort = 1'b1;
    at_edge(102);
    abort = 1'b0;

    // abort before the first step completes: straight to IDLE
    push_seq(115, 3, 4, 116, 1000);
    push_idle(117, 119);
    start(115, 3, 4, 1);
    at_edge(116);
    abort = 1'b1;
    at_edge(117);
    abort = 1'b0;

    // reset during HOLD, then a normal restart
    push_seq(120, 4, 1, 174, 129);
    push_idle(130, 134);
    start(120, 4, 1, 50);
    at_edge(130);
    rst = 1'b1;
    at_edge(131);
    rst = 1'b0;

    push_seq(135, 3, 2, 135 + 6 + 2, 1000);
    push_idle(150, 154);
    start(135, 3, 2, 2);

    for (int i = 0; i < 500 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check_val("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
